// File: rtl/axi_llc_b_merger.sv
// Merges per-cache-line write completions back into one AXI B response per original AW burst.
// Define AXI_LLC_B_MERGER_ID_CHECK_EN to enable sticky ID-mismatch/overflow detection on id_err_o.
module axi_llc_b_merger #(
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned MaxParts  = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               desc_valid_i,
    output logic               desc_ready_o,
    input  logic [IdWidth-1:0] desc_id_i,
    input  logic [1:0]         desc_resp_i,
    input  logic               desc_last_i,
    output logic               b_valid_o,
    input  logic               b_ready_i,
    output logic [IdWidth-1:0] b_id_o,
    output logic [1:0]         b_resp_o,
    output logic               busy_o,
    output logic               id_err_o
);

    localparam int unsigned CntW  = $clog2(MaxParts + 1);
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned FillW = $clog2(FifoDepth + 1);

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    // Severity rank: DECERR > SLVERR > OKAY > EXOKAY.
    function automatic logic [1:0] resp_rank(input logic [1:0] r);
        case (r)
            2'b11:   return 2'd3;
            2'b10:   return 2'd2;
            2'b00:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
        return (resp_rank(a) >= resp_rank(b)) ? a : b;
    endfunction

    state_e             state_q, state_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic [1:0]         acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [IdWidth+1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [FillW-1:0]   fill_q;

    logic               full, accept, overflow, push, pop;
    logic [IdWidth-1:0] push_id;
    logic [1:0]         push_resp;

    assign full         = (fill_q == FillW'(FifoDepth));
    assign desc_ready_o = !rst_i && (!desc_last_i || !full);
    assign accept       = desc_valid_i && desc_ready_o;
    assign overflow     = accept && !desc_last_i && (cnt_q == CntW'(MaxParts - 1));
    assign pop          = b_valid_o && b_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            id_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!desc_last_i) begin
                        state_d = StMerge;
                        id_d    = desc_id_i;
                        acc_d   = desc_resp_i;
                        cnt_d   = overflow ? cnt_q : cnt_q + CntW'(1);
                    end
                end
                StMerge: begin
                    if (desc_last_i) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        acc_d = merge_resp(acc_q, desc_resp_i);
                        cnt_d = overflow ? cnt_q : cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        push      = accept && desc_last_i;
        push_id   = (state_q == StMerge) ? id_q : desc_id_i;
        push_resp = (state_q == StMerge) ? merge_resp(acc_q, desc_resp_i) : desc_resp_i;
        busy_o    = (state_q == StMerge) || (fill_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= {push_id, push_resp};
                wptr_q <= (wptr_q == PtrW'(FifoDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrW'(FifoDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FillW'(1);
                2'b01:   fill_q <= fill_q - FillW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign b_valid_o = (fill_q != '0);
    assign b_id_o    = mem_q[rptr_q][IdWidth+1:2];
    assign b_resp_o  = mem_q[rptr_q][1:0];

`ifdef AXI_LLC_B_MERGER_ID_CHECK_EN
    logic id_err_q, id_err_set;

    assign id_err_set = overflow || (accept && (state_q == StMerge) && (desc_id_i != id_q));

    always_ff @(posedge clk_i) begin
        if (rst_i)           id_err_q <= 1'b0;
        else if (id_err_set) id_err_q <= 1'b1;
    end

    assign id_err_o = id_err_q;

    a_no_id_err: assert property (@(posedge clk_i) disable iff (rst_i) !id_err_set)
        else $error("axi_llc_b_merger: ID mismatch or part counter overflow");
`else
    assign id_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_llc_b_merger.sv
// Self-checking bench for axi_llc_b_merger: directed scenarios plus randomized bursts
// checked against a queue-based model of the response merge.
module tb_axi_llc_b_merger;

    logic       clk = 1'b0;
    logic       rst;
    logic       desc_valid, desc_ready, desc_last;
    logic [5:0] desc_id;
    logic [1:0] desc_resp;
    logic       b_valid, b_ready;
    logic [5:0] b_id;
    logic [1:0] b_resp;
    logic       busy, id_err;

    axi_llc_b_merger #(.IdWidth(6), .FifoDepth(2), .MaxParts(256)) dut (
        .clk_i(clk), .rst_i(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready), .desc_id_i(desc_id),
        .desc_resp_i(desc_resp), .desc_last_i(desc_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .busy_o(busy), .id_err_o(id_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    b_t         exp_q[$];
    logic [1:0] part_q[$];
    logic [5:0] cur_id;
    bit         in_burst   = 0;
    bit         rand_ready = 0;
    b_t         mon_e;

    // Reference: worst response among all parts of the burst.
    function automatic logic [1:0] model_resp();
        bit any_dec = 0, any_slv = 0, any_ok = 0;
        foreach (part_q[i]) begin
            if (part_q[i] == 2'b11) any_dec = 1;
            if (part_q[i] == 2'b10) any_slv = 1;
            if (part_q[i] == 2'b00) any_ok = 1;
        end
        if (any_dec) return 2'b11;
        if (any_slv) return 2'b10;
        if (any_ok)  return 2'b00;
        return 2'b01;
    endfunction

    task automatic model_accept(input logic [5:0] id, input logic [1:0] resp, input logic last);
        b_t e;
        if (!in_burst) cur_id = id;
        in_burst = 1;
        part_q.push_back(resp);
        if (last) begin
            e.id   = cur_id;
            e.resp = model_resp();
            exp_q.push_back(e);
            part_q.delete();
            in_burst = 0;
        end
    endtask

    // Every B transfer is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_b: got id=%0d resp=%0d, required no B", b_id, b_resp);
            end else begin
                mon_e = exp_q.pop_front();
                if ({b_id, b_resp} !== mon_e) begin
                    n_fail++;
                    $display("FAIL b_beat: got id=%0d resp=%0d, required id=%0d resp=%0d",
                             b_id, b_resp, mon_e.id, mon_e.resp);
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic send_part(input logic [5:0] id, input logic [1:0] resp, input logic last);
        bit acc = 0;
        desc_valid = 1'b1;
        desc_id    = id;
        desc_resp  = resp;
        desc_last  = last;
        for (int c = 0; c < 200; c++) begin
            if (rand_ready) b_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (desc_ready) acc = 1;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        desc_valid = 1'b0;
        desc_last  = 1'b0;
        if (acc) begin
            model_accept(id, resp, last);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: part id=%0d never accepted, required acceptance", id);
        end
    endtask

    task automatic drain();
        rand_ready = 0;
        b_ready    = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: busy=%0b pending=%0d, required busy=0 pending=0",
                     busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        desc_valid = 1'b1;
        desc_last  = 1'b0;
        desc_id    = 6'd0;
        desc_resp  = 2'b00;
        b_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (desc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_desc_ready: got %0b, required 0", desc_ready); end
        if (b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %0b, required 0", b_valid); end
        if (b_id !== 6'd0) begin n_fail++; $display("FAIL rst_b_id: got %0d, required 0", b_id); end
        if (b_resp !== 2'd0) begin n_fail++; $display("FAIL rst_b_resp: got %0d, required 0", b_resp); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b, required 0", busy); end
        if (id_err !== 1'b0) begin n_fail++; $display("FAIL rst_id_err: got %0b, required 0", id_err); end
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_single();
        send_part(6'd5, 2'b00, 1'b1);
        @(negedge clk);
        n_checks++;
        if (b_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: b_valid=%0b, required 1", b_valid); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0b, required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_three_part();
        send_part(6'd3, 2'b00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL three_mid: busy=%0b b_valid=%0b, required busy=1 b_valid=0", busy, b_valid);
        end
        @(posedge clk);
        #1;
        send_part(6'd3, 2'b10, 1'b0);
        send_part(6'd3, 2'b00, 1'b1);
        @(negedge clk);
        n_checks++;
        if (b_valid !== 1'b1) begin n_fail++; $display("FAIL three_latency: b_valid=%0b, required 1", b_valid); end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_merge_exokay_decerr();
        send_part(6'd9, 2'b01, 1'b0);
        send_part(6'd9, 2'b01, 1'b1);
        drain();
        send_part(6'd10, 2'b01, 1'b0);
        send_part(6'd10, 2'b11, 1'b0);
        send_part(6'd10, 2'b10, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        b_ready = 1'b0;
        send_part(6'd1, 2'b00, 1'b1);
        send_part(6'd2, 2'b10, 1'b1);
        desc_valid = 1'b1;
        desc_id    = 6'd3;
        desc_resp  = 2'b01;
        desc_last  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (desc_ready !== 1'b1) begin n_fail++; $display("FAIL bp_nonlast_ready: got %0b, required 1", desc_ready); end
        @(posedge clk);
        #1;
        model_accept(6'd3, 2'b01, 1'b0);
        desc_last = 1'b1;
        desc_resp = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (desc_ready !== 1'b0) begin n_fail++; $display("FAIL bp_last_stall: got %0b, required 0", desc_ready); end
            @(posedge clk);
            #1;
        end
        b_ready = 1'b1;
        send_part(6'd3, 2'b11, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] r;
        send_part(6'd6, 2'b11, 1'b0);
        send_part(6'd6, 2'b10, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        part_q.delete();
        exp_q.delete();
        in_burst = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: busy=%0b b_valid=%0b, required 0 0", busy, b_valid);
        end
        @(posedge clk);
        #1;
        r = 2'($urandom_range(0, 3));
        send_part(6'd7, r, 1'b1);
        drain();
    endtask

    task automatic test_id_check();
        logic exp_err;
`ifdef AXI_LLC_B_MERGER_ID_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_part(6'd2, 2'b00, 1'b0);
        send_part(6'd4, 2'b00, 1'b1);
        drain();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (id_err !== exp_err) begin
                n_fail++;
                $display("FAIL id_err: got %0b, required %0b", id_err, exp_err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int         len;
        logic [5:0] id;
        rand_ready = 1;
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, 6);
            id  = 6'($urandom_range(0, 63));
            for (int p = 0; p < len; p++) begin
                send_part(id, 2'($urandom_range(0, 3)), (p == len - 1) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_part();
        test_merge_exokay_decerr();
        test_backpressure();
        test_reset_mid_burst();
        test_id_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_llc_b_merger.md
Name: axi_llc_b_merger

Overview:
- Inverse of the write-side burst cutter: takes the stream of per-cache-line write descriptor completions from the LLC write path and merges them back into one AXI B response per original AW burst.
- Each original burst yields 1..256 descriptor completions, delivered in order and contiguously, with the last one flagged.
- The block combines their responses and emits a single B beat through a small output FIFO.
- Sits between the LLC write unit completion port and the slave-side B channel.

Parameters:
- IdWidth, 6, width of AXI ID.
- FifoDepth, 2, depth of B output FIFO (≥1).
- MaxParts, 256, maximum descriptors per burst; sets part counter width to clog2(MaxParts+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- desc_valid_i  in  1  completion valid.
- desc_ready_o  out  1  completion accepted.
- desc_id_i  in  IdWidth  AXI ID of descriptor.
- desc_resp_i  in  2  axi_pkg resp of this line part.
- desc_last_i  in  1  final part of original burst (x_last).
- b_valid_o  out  1  B valid.
- b_ready_i  in  1  B ready.
- b_id_o  out  IdWidth  B ID.
- b_resp_o  out  2  merged B resp.
- busy_o  out  1  burst partially merged or FIFO non-empty.
- id_err_o  out  1  sticky ID-mismatch flag; see Optional Feature.

Behaviour:
- Reset: every output 0; accumulator, counter and FIFO cleared. Reset mid-burst drops partial merge state and FIFO contents, with no B emitted.
- Handshake:
  - Completion accepted when desc_valid_i && desc_ready_o.
  - B transferred when b_valid_o && b_ready_i.
  - b_valid_o/b_id_o/b_resp_o stay stable until accepted.
- desc_ready_o = 1 for non-last parts always; for last parts = !fifo_full. No combinational path from b_ready_i.
- States:
  - IDLE (no partial burst).
  - MERGE (≥1 non-last part accepted).
- Transitions:
  - IDLE + accepted non-last -> MERGE: latch id, acc_resp = desc_resp_i, cnt = 1.
  - IDLE + accepted last -> push {desc_id_i, desc_resp_i} into FIFO, stay IDLE.
  - MERGE + accepted non-last -> acc_resp = merge(acc, in), cnt++.
  - MERGE + accepted last -> push {latched id, merge(acc, in)}, return to IDLE, cnt = 0.
- Merge severity: DECERR > SLVERR > OKAY > EXOKAY.
  - Any DECERR gives DECERR; else any SLVERR gives SLVERR; else any OKAY gives OKAY; else EXOKAY.
  - Merge is commutative.
- Latency: last part accepted in cycle N -> b_valid_o high in N+1 if FIFO was empty.
- FIFO:
  - Simultaneous push and pop allowed when non-full.
  - When full, last parts stall while non-last parts continue accumulating.
- Counter overflow: a non-last part arriving with cnt == MaxParts-1 is a protocol error. The counter saturates, the part is still accepted, and id_err_o is set if the feature is enabled.
- busy_o = (state == MERGE) || fifo_not_empty.

Optional Feature:
- Macro AXI_LLC_B_MERGER_ID_CHECK_EN.
- When defined:
  - In MERGE, each accepted part whose desc_id_i differs from the latched id sets id_err_o.
  - Counter saturation also sets id_err_o.
  - id_err_o is sticky until rst_i; merging proceeds with the latched id.
  - Adds a simulation assertion that fires on either event.
- When undefined: id_err_o tied to 0; no comparison logic.

Test Plan:
- Single-line burst: one part id=5 resp=OKAY last=1, b_ready_i=1 -> one B id=5 resp=OKAY the next cycle; busy_o returns to 0.
- Three-part burst id=3, resps OKAY, SLVERR, OKAY (last on third) -> exactly one B id=3 resp=SLVERR, one cycle after the third part.
- EXOKAY/DECERR merge:
  - Parts EXOKAY, EXOKAY(last) -> B resp=EXOKAY.
  - Parts EXOKAY, DECERR, SLVERR(last) -> B resp=DECERR.
- Backpressure with FifoDepth=2, b_ready_i=0:
  - Three single-part bursts -> desc_ready_o drops on the third.
  - A non-last part is still accepted while stalled.
  - Raising b_ready_i drains B in order id 1, 2, 3.
- Reset mid-burst: 2 non-last parts, assert rst_i for one cycle, then one part id=7 last=1 -> single B id=7 with only that part's resp; no stale B.
- ID check with macro defined: parts id=2, then id=4 (last) -> id_err_o=1 and stays 1; B id=2. With macro undefined, same stimulus -> id_err_o=0.
